// File: rtl/axis_bram_stream_bridge.sv
// axis_bram_stream_bridge: gathers AXI-Stream words into BRAM lines (write mode)
// or fetches BRAM lines and serialises them onto AXI-Stream (read mode).
// All outputs are registered; their next values are derived from the next state.
module axis_bram_stream_bridge #(
  parameter  int unsigned DATA_W         = 32,
  parameter  int unsigned WORDS_PER_LINE = 36,
  parameter  int unsigned ADDR_W         = 12,
  localparam int unsigned LINE_W         = DATA_W * WORDS_PER_LINE,
  localparam int unsigned PTR_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cfg_start,
  input  logic                      cfg_mode,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [ADDR_W-1:0]         cfg_len,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         lines_done,
  input  logic [DATA_W-1:0]         s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      bram_en,
  output logic [WORDS_PER_LINE-1:0] bram_we,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [LINE_W-1:0]         bram_din,
  input  logic [LINE_W-1:0]         bram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FILL,
    S_WR_COMMIT,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_RD_SEND,
    S_DONE
  } state_t;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS_PER_LINE - 1);

  state_t                                   r_state;
  state_t                                   w_state_nxt;

  logic [ADDR_W-1:0]                        r_base, w_base_nxt;
  logic [ADDR_W-1:0]                        r_len, w_len_nxt;
  logic [ADDR_W-1:0]                        r_lines, w_lines_nxt;
  logic [ADDR_W-1:0]                        w_lines_inc;
  logic [PTR_W-1:0]                         r_ptr, w_ptr_nxt;
  logic [WORDS_PER_LINE-1:0]                r_mask, w_mask_nxt;
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]    r_buf, w_buf_nxt;
  logic                                     r_tlast_seen, w_tlast_seen_nxt;

  logic                                     r_busy, w_busy_nxt;
  logic                                     r_done, w_done_nxt;
  logic                                     r_s_tready, w_s_tready_nxt;
  logic                                     r_m_tvalid, w_m_tvalid_nxt;
  logic                                     r_m_tlast, w_m_tlast_nxt;
  logic [DATA_W-1:0]                        r_m_tdata, w_m_tdata_nxt;
  logic                                     r_bram_en, w_bram_en_nxt;
  logic [WORDS_PER_LINE-1:0]                r_bram_we, w_bram_we_nxt;
  logic [ADDR_W-1:0]                        r_bram_addr, w_bram_addr_nxt;

  logic                                     w_s_hs;
  logic                                     w_m_hs;

  assign w_lines_inc = r_lines + ADDR_W'(1);
  assign w_s_hs      = r_s_tready & s_axis_tvalid;
  assign w_m_hs      = r_m_tvalid & m_axis_tready;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_len_nxt        = r_len;
    w_lines_nxt      = r_lines;
    w_ptr_nxt        = r_ptr;
    w_mask_nxt       = r_mask;
    w_buf_nxt        = r_buf;
    w_tlast_seen_nxt = r_tlast_seen;

    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_base_nxt       = cfg_base;
          w_len_nxt        = cfg_len;
          w_lines_nxt      = '0;
          w_ptr_nxt        = '0;
          w_mask_nxt       = '0;
          w_buf_nxt        = '0;
          w_tlast_seen_nxt = 1'b0;
          if (cfg_len == '0) begin
            w_state_nxt = S_DONE;
          end else if (cfg_mode) begin
            w_state_nxt = S_RD_ISSUE;
          end else begin
            w_state_nxt = S_WR_FILL;
          end
        end
      end
      S_WR_FILL: begin
        if (w_s_hs) begin
          w_buf_nxt[r_ptr]  = s_axis_tdata;
          w_mask_nxt[r_ptr] = 1'b1;
          if ((r_ptr == LAST_PTR) || s_axis_tlast) begin
            w_ptr_nxt        = '0;
            w_tlast_seen_nxt = s_axis_tlast;
            w_state_nxt      = S_WR_COMMIT;
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
        end
      end
      S_WR_COMMIT: begin
        w_lines_nxt      = w_lines_inc;
        w_ptr_nxt        = '0;
        w_mask_nxt       = '0;
        w_buf_nxt        = '0;
        w_tlast_seen_nxt = 1'b0;
        if (r_tlast_seen || (w_lines_inc == r_len)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WR_FILL;
        end
      end
      S_RD_ISSUE: begin
        w_state_nxt = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: begin
        w_buf_nxt   = bram_dout;
        w_ptr_nxt   = '0;
        w_state_nxt = S_RD_SEND;
      end
      S_RD_SEND: begin
        if (w_m_hs) begin
          if (r_ptr == LAST_PTR) begin
            w_lines_nxt = w_lines_inc;
            if (w_lines_inc == r_len) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_RD_ISSUE;
            end
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs for the cycle in which w_state_nxt becomes the current state
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_s_tready_nxt  = (w_state_nxt == S_WR_FILL);
    w_m_tvalid_nxt  = 1'b0;
    w_m_tlast_nxt   = 1'b0;
    w_m_tdata_nxt   = r_m_tdata;
    w_bram_en_nxt   = 1'b0;
    w_bram_we_nxt   = '0;
    w_bram_addr_nxt = r_bram_addr;

    if (w_state_nxt == S_RD_SEND) begin
      w_m_tvalid_nxt = 1'b1;
      w_m_tdata_nxt  = w_buf_nxt[w_ptr_nxt];
      w_m_tlast_nxt  = (w_ptr_nxt == LAST_PTR) &&
                       (w_lines_nxt == (w_len_nxt - ADDR_W'(1)));
    end

    if (w_state_nxt == S_WR_COMMIT) begin
      w_bram_en_nxt   = 1'b1;
      w_bram_we_nxt   = w_mask_nxt;
      w_bram_addr_nxt = w_base_nxt + w_lines_nxt;
    end else if (w_state_nxt == S_RD_ISSUE) begin
      w_bram_en_nxt   = 1'b1;
      w_bram_addr_nxt = w_base_nxt + w_lines_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_base       <= '0;
      r_len        <= '0;
      r_lines      <= '0;
      r_ptr        <= '0;
      r_mask       <= '0;
      r_buf        <= '0;
      r_tlast_seen <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s_tready   <= 1'b0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= '0;
      r_bram_en    <= 1'b0;
      r_bram_we    <= '0;
      r_bram_addr  <= '0;
    end else begin
      r_base       <= w_base_nxt;
      r_len        <= w_len_nxt;
      r_lines      <= w_lines_nxt;
      r_ptr        <= w_ptr_nxt;
      r_mask       <= w_mask_nxt;
      r_buf        <= w_buf_nxt;
      r_tlast_seen <= w_tlast_seen_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_s_tready   <= w_s_tready_nxt;
      r_m_tvalid   <= w_m_tvalid_nxt;
      r_m_tlast    <= w_m_tlast_nxt;
      r_m_tdata    <= w_m_tdata_nxt;
      r_bram_en    <= w_bram_en_nxt;
      r_bram_we    <= w_bram_we_nxt;
      r_bram_addr  <= w_bram_addr_nxt;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign lines_done    = r_lines;
  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign bram_en       = r_bram_en;
  assign bram_we       = r_bram_we;
  assign bram_addr     = r_bram_addr;
  assign bram_din      = r_buf;

endmodule

// File: doc/axis_bram_stream_bridge.md
Name: axis_bram_stream_bridge

Overview:
Parametrised bidirectional bridge between a 32-bit-class AXI-Stream pair and a wide single-port BRAM line of WORDS_PER_LINE words. Write mode gathers stream words into a line buffer and commits whole or partial lines with per-word write enables. Read mode fetches lines and serialises them onto the master stream with TLAST on the final word. It is configured by a start/base/length strobe interface driven by the existing AXI-Lite register block.

Parameters:
DATA_W, 32, stream word width in bits
WORDS_PER_LINE, 36, words per BRAM line (>=2)
ADDR_W, 12, BRAM line-address width
LINE_W, DATA_W*WORDS_PER_LINE, BRAM data width (derived, do not override)
PTR_W, clog2(WORDS_PER_LINE), word-pointer width (derived)

Ports:
aclk  in  1  sole clock; BRAM is on the same clock
aresetn  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle start strobe; sampled only in IDLE
cfg_mode  in  1  0=write (stream->BRAM), 1=read (BRAM->stream); sampled with cfg_start
cfg_base  in  ADDR_W  first line address
cfg_len  in  ADDR_W  number of lines
busy  out  1  high from start-accept until DONE
done  out  1  one-cycle pulse at end of transfer
lines_done  out  ADDR_W  lines committed or fetched in the last/current transfer
s_axis_tdata  in  DATA_W  input stream data
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end-of-packet
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  output stream data
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last word of transfer
m_axis_tready  in  1  output ready
bram_en  out  1  BRAM enable
bram_we  out  WORDS_PER_LINE  per-word write enable
bram_addr  out  ADDR_W  line address
bram_din  out  LINE_W  write data (line buffer)
bram_dout  in  LINE_W  read data, valid 1 cycle after bram_en with bram_we=0

Behaviour:
- Reset: state=IDLE. busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast, bram_en, bram_we, bram_addr, lines_done, line buffer, word ptr, word mask and tlast flag all 0. m_axis_tdata=0.
- States: IDLE, WR_FILL, WR_COMMIT, RD_ISSUE, RD_CAPTURE, RD_SEND, DONE.
- IDLE: on cfg_start, latch cfg_*, clear lines_done/ptr/mask, go to busy. If cfg_len==0 go to DONE (no BRAM access, no stream beats). Otherwise go to WR_FILL (mode 0) or RD_ISSUE (mode 1). cfg_start outside IDLE is ignored.
- WR_FILL: s_axis_tready=1. On a handshake, buffer[ptr]<=tdata, mask[ptr]<=1, ptr++. If ptr==WORDS_PER_LINE-1 or tlast, go to WR_COMMIT and record tlast.
- WR_COMMIT (1 cycle, tready=0): bram_en=1, bram_we=mask, bram_addr=cfg_base+lines_done. Address arithmetic is modulo 2^ADDR_W (wraps). Unwritten words of a partial line are driven 0 and not enabled. Then lines_done++, ptr=0, mask=0, buffer cleared. Go to DONE if tlast was seen or lines_done+1==cfg_len, else WR_FILL. After the limit is reached, further beats are not accepted.
- RD_ISSUE: bram_en=1, we=0, addr=cfg_base+lines_done (wrapping). Next state RD_CAPTURE.
- RD_CAPTURE: buffer<=bram_dout, ptr=0, then RD_SEND. First tvalid appears 2 cycles after RD_ISSUE.
- RD_SEND: m_axis_tvalid=1, tdata=buffer[ptr]; tdata and tlast are held stable until tready. tlast=1 only when ptr==WORDS_PER_LINE-1 and lines_done==cfg_len-1. On handshake at the last word: lines_done++, then DONE if the transfer is complete, else RD_ISSUE. Otherwise ptr++.
- DONE: done=1 for one cycle, busy=0 from the next cycle; return to IDLE. lines_done holds until the next start.
- bram_en is never asserted outside WR_COMMIT/RD_ISSUE. s_axis_tready=0 in all read states; m_axis_tvalid=0 in all write states.
- Reset asserted mid-operation: immediate return to reset values. The partially gathered line is discarded, not written.

Test Plan:
- WORDS_PER_LINE=4, write base=0x010 len=2, 8 beats (tlast on beat 8) -> BRAM writes at 0x010 and 0x011, we=4'b1111, correct word order; done pulse; lines_done=2.
- Write base=0x010 len=4, tlast on beat 6 -> 0x010 we=1111; 0x011 we=0011, upper words 0; done; lines_done=2; beat 7 not accepted.
- Read len=3, m_axis_tready toggled 1/0 -> 12 beats in line/word order; data stable during stalls; tlast only on beat 12; first tvalid 2 cycles after first bram_en.
- cfg_len=0 start -> done pulse, no bram_en, no stream beats; cfg_start during busy is ignored (no restart, lines_done unaffected).
- base=0xFFF len=2 (ADDR_W=12), both modes -> addresses 0xFFF then 0x000.
- aresetn low mid-write (after 2 beats) -> no BRAM write, all outputs at reset values; next write transfer completes normally.
